// File: rtl/laser_fire_seq_if.sv
// laser_fire_seq_if: mask-table config write bus.
// master: drives i_cfg_wr/i_cfg_addr/i_cfg_data; slave: the sequencer.
interface laser_fire_seq_if;
  logic       i_cfg_wr;
  logic [3:0] i_cfg_addr;
  logic [7:0] i_cfg_data;

  modport master (
    output i_cfg_wr,
    output i_cfg_addr,
    output i_cfg_data
  );

  modport slave (
    input i_cfg_wr,
    input i_cfg_addr,
    input i_cfg_data
  );
endinterface

// File: rtl/laser_fire_seq.sv
// laser_fire_seq: angle-synced laser strobe sequencer with TDC mask table.
// Ports: i_clk_100m, i_rst_n (async, low), i_angle_sync, i_cdctdc_ready,
// i_mode, i_fix_chn, cfg (slave write bus), o_laser_str, o_laser_sync,
// o_tdc1_chnlmask, o_tdc2_chnlmask, o_laser_sernum, o_busy.
// Optional LASER_SYNC_MISS_EN adds o_sync_miss_cnt.
module laser_fire_seq #(
  parameter int LASER_NUM = 8,
  parameter int PULSE_W   = 1,
  parameter int HOLDOFF   = 4
) (
  input  logic                 i_clk_100m,
  input  logic                 i_rst_n,
  input  logic                 i_angle_sync,
  input  logic                 i_cdctdc_ready,
  input  logic [1:0]           i_mode,
  input  logic [3:0]           i_fix_chn,
  laser_fire_seq_if.slave      cfg,
  output logic [LASER_NUM-1:0] o_laser_str,
  output logic                 o_laser_sync,
  output logic [3:0]           o_tdc1_chnlmask,
  output logic [3:0]           o_tdc2_chnlmask,
  output logic [3:0]           o_laser_sernum,
  output logic                 o_busy
`ifdef LASER_SYNC_MISS_EN
  ,
  output logic [15:0]          o_sync_miss_cnt
`endif
);

  localparam logic [1:0] M_ASC = 2'b00;
  localparam logic [1:0] M_DSC = 2'b01;
  localparam logic [1:0] M_FIX = 2'b10;
  localparam logic [1:0] M_ALL = 2'b11;

  localparam logic [3:0] CH_LAST = 4'(LASER_NUM - 1);
  localparam logic [4:0] CH_NUM  = 5'(LASER_NUM);
  localparam logic [7:0] PW_LAST = 8'(PULSE_W - 1);
  localparam logic [7:0] HO_LAST = 8'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam bit         HO_SKIP = (HOLDOFF == 0);

  localparam logic [LASER_NUM-1:0] ONE =
    {{(LASER_NUM-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_READY,
    S_FIRE,
    S_HOLD
  } state_t;

  function automatic logic [7:0] dflt_mask(input int i);
    case (i)
      0:       dflt_mask = 8'h0C;
      1:       dflt_mask = 8'hF0;
      2:       dflt_mask = 8'hE0;
      3:       dflt_mask = 8'hD0;
      4:       dflt_mask = 8'hC0;
      5:       dflt_mask = 8'h0F;
      6:       dflt_mask = 8'h0E;
      7:       dflt_mask = 8'h0D;
      default: dflt_mask = 8'h0C;
    endcase
  endfunction

  state_t               state;
  logic [7:0]           cnt;
  logic [3:0]           idx;
  logic [7:0]           tbl [16];

  // Firing parameters captured at sync acceptance.
  logic [1:0]           p_mode;
  logic [3:0]           p_chn;
  logic [LASER_NUM-1:0] p_pat;
  logic [7:0]           p_mask;

  logic                 accept;
  logic [3:0]           fix_cl;
  logic [3:0]           sel_chn;
  logic [LASER_NUM-1:0] sel_pat;
  logic [7:0]           sel_mask;

  always_comb begin
    accept   = (state == S_READY) && i_cdctdc_ready
               && i_angle_sync;
    fix_cl   = ({1'b0, i_fix_chn} >= CH_NUM) ? CH_LAST
               : i_fix_chn;
    sel_chn  = (i_mode == M_FIX) ? fix_cl : idx;
    sel_pat  = (i_mode == M_ALL) ? '1 : (ONE << sel_chn);
    sel_mask = (i_mode == M_ALL) ? 8'hFF : tbl[sel_chn];
  end

  always_ff @(posedge i_clk_100m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= S_IDLE;
      cnt             <= '0;
      idx             <= '0;
      p_mode          <= M_ASC;
      p_chn           <= '0;
      p_pat           <= '0;
      p_mask          <= 8'h0C;
      o_laser_str     <= '0;
      o_laser_sync    <= 1'b0;
      o_busy          <= 1'b0;
      o_laser_sernum  <= '0;
      o_tdc1_chnlmask <= 4'hC;
      o_tdc2_chnlmask <= 4'h0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_cdctdc_ready) state <= S_READY;
        end
        S_READY: begin
          if (!i_cdctdc_ready) begin
            state <= S_IDLE;
          end else if (accept) begin
            state  <= S_FIRE;
            cnt    <= '0;
            p_mode <= i_mode;
            p_chn  <= sel_chn;
            p_pat  <= sel_pat;
            p_mask <= sel_mask;
          end
        end
        S_FIRE: begin
          if (cnt == PW_LAST) begin
            cnt   <= '0;
            state <= HO_SKIP ? S_IDLE : S_HOLD;
            if (p_mode == M_ASC)
              idx <= (idx == CH_LAST) ? 4'd0 : idx + 4'd1;
            else if (p_mode == M_DSC)
              idx <= (idx == 4'd0) ? CH_LAST : idx - 4'd1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_HOLD: begin
          if (cnt == HO_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase

      o_laser_str  <= (state == S_FIRE) ? p_pat : '0;
      o_laser_sync <= (state == S_FIRE);
      o_busy       <= (state == S_FIRE) || (state == S_HOLD);

      // First FIRE cycle: result regs update with the strobe edge.
      if (state == S_FIRE && cnt == 8'd0) begin
        o_laser_sernum  <= p_chn;
        o_tdc1_chnlmask <= p_mask[3:0];
        o_tdc2_chnlmask <= p_mask[7:4];
      end
    end
  end

  always_ff @(posedge i_clk_100m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 16; i++) tbl[i] <= dflt_mask(i);
    end else if (cfg.i_cfg_wr && ({1'b0, cfg.i_cfg_addr} < CH_NUM)) begin
      tbl[cfg.i_cfg_addr] <= cfg.i_cfg_data;
    end
  end

`ifdef LASER_SYNC_MISS_EN
  always_ff @(posedge i_clk_100m or negedge i_rst_n) begin
    if (!i_rst_n)
      o_sync_miss_cnt <= '0;
    else if (i_angle_sync && !accept && o_sync_miss_cnt != 16'hFFFF)
      o_sync_miss_cnt <= o_sync_miss_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/laser_fire_seq.md
LASER_FIRE_SEQ -- requirements
Module: laser_fire_seq

Interface
REQ-001 SHALL have parameter LASER_NUM, default 8, meaning the number of laser channels; legal range 2..16.
REQ-002 SHALL have parameter PULSE_W, default 1, meaning the strobe width in clock cycles; legal range 1..255.
REQ-003 SHALL have parameter HOLDOFF, default 4, meaning the dead cycles after each strobe before re-arming; legal range 0..255.
REQ-004 SHALL have port i_clk_100m, input, 1 bit: the single clock.
REQ-005 SHALL have port i_rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 SHALL have port i_angle_sync, input, 1 bit: a one-cycle angle tick that requests a firing.
REQ-007 SHALL have port i_cdctdc_ready, input, 1 bit: the TDC is armed.
REQ-008 SHALL have port i_mode, input, 2 bits: 00 ascending rotate, 01 descending rotate, 10 fixed channel, 11 all-fire.
REQ-009 SHALL have port i_fix_chn, input, 4 bits: the channel used in fixed mode.
REQ-010 SHALL have ports i_cfg_wr (1 bit), i_cfg_addr (4 bits) and i_cfg_data (8 bits), all inputs: a write port into the per-channel TDC mask table.
REQ-011 SHALL have port o_laser_str, output, LASER_NUM bits: one-hot laser strobes.
REQ-012 SHALL have port o_laser_sync, output, 1 bit: high while any strobe is active.
REQ-013 SHALL have ports o_tdc1_chnlmask and o_tdc2_chnlmask, outputs, 4 bits each: the mask table entry [3:0] and [7:4] for the fired channel.
REQ-014 SHALL have port o_laser_sernum, output, 4 bits: the index of the fired channel.
REQ-015 SHALL have port o_busy, output, 1 bit: high in FIRE or HOLDOFF.

Function
REQ-016 SHALL implement the states IDLE, READY, FIRE and HOLDOFF.
- IDLE->READY when i_cdctdc_ready=1.
- READY->IDLE when i_cdctdc_ready=0.
- READY->FIRE when i_angle_sync=1 (this is the sync acceptance).
REQ-017 SHALL stay in FIRE for exactly PULSE_W cycles, then stay in HOLDOFF for HOLDOFF cycles (skipped when HOLDOFF=0), then go to IDLE.
REQ-018 SHALL register o_laser_str, o_laser_sync and o_busy from the state, so the strobe rises one cycle after FIRE is entered and is high for PULSE_W cycles.
REQ-019 SHALL sample i_mode and i_fix_chn at sync acceptance only; changes at any other time have no effect on the current firing.
REQ-020 SHALL drive o_laser_str as follows:
- ascending, descending or fixed mode: 1<<chn, where chn is the channel index or i_fix_chn.
- all-fire mode: all LASER_NUM bits high.
REQ-021 SHALL clamp i_fix_chn values >= LASER_NUM to LASER_NUM-1.
REQ-022 SHALL keep a channel index, reset 0, that advances at the last FIRE cycle in the rotate modes only:
- ascending: LASER_NUM-1 wraps to 0.
- descending: 0 wraps to LASER_NUM-1.
REQ-023 SHALL load o_laser_sernum, o_tdc1_chnlmask and o_tdc2_chnlmask in the same cycle the strobe rises, and hold them until the next firing.
REQ-024 SHALL set both masks to 4'hF in all-fire mode, with o_laser_sernum = the current channel index.
REQ-025 SHALL write mask table entry i_cfg_addr on i_cfg_wr=1; writes with i_cfg_addr >= LASER_NUM are ignored.
REQ-026 SHALL make a table write to the currently firing channel take effect at the next firing; already-loaded masks do not change.
REQ-027 SHALL ignore i_angle_sync in IDLE, FIRE and HOLDOFF; no queuing.

Reset
REQ-028 SHALL, on i_rst_n=0, immediately and asynchronously set:
- state IDLE, channel index 0.
- o_laser_str, o_laser_sync and o_busy = 0.
- o_laser_sernum = 0, o_tdc1_chnlmask = 4'hC, o_tdc2_chnlmask = 4'h0.
REQ-029 SHALL abort a strobe when reset is asserted mid-FIRE; after reset release the first firing is channel 0.
REQ-030 SHALL reset the mask table to entries 0..7 = 0C, F0, E0, D0, C0, 0F, 0E, 0D and entries 8..15 = 0C.

Configuration
REQ-031 SHALL, when LASER_SYNC_MISS_EN is defined, add output o_sync_miss_cnt (16 bits, reset 0, saturating at FFFF) that increments on each i_angle_sync=1 not accepted per REQ-027.
REQ-032 SHALL, when LASER_SYNC_MISS_EN is undefined, omit the port and its logic entirely, with all other behaviour unchanged.

Verification
REQ-033 SHALL cover: ready=1, mode 00, 9 syncs spaced 20 cycles -> sernum 0,1..7,0; strobes 01,02..80,01; tdc1/tdc2 per the REQ-030 table.
REQ-034 SHALL cover: mode 01, 3 syncs -> sernum 0,7,6; with PULSE_W=3 each strobe is exactly 3 cycles and rises 1 cycle after the accepted sync.
REQ-035 SHALL cover: mode 10 with i_fix_chn=12 and LASER_NUM=8 -> str 80, sernum 7, masks D/0, index unchanged; mode 11 -> str FF, masks F/F.
REQ-036 SHALL cover: sync 2 cycles after an accepted sync (HOLDOFF=4) -> no strobe, and o_sync_miss_cnt=1 when the macro is defined.
REQ-037 SHALL cover: cfg write addr 1 data A5 then fire channel 1 -> tdc1=5, tdc2=A; a write to addr 9 with LASER_NUM=8 -> table unchanged.
REQ-038 SHALL cover: i_rst_n pulsed low mid-strobe -> str=0 the same cycle; next firing is channel 0 with table defaults restored.
